// File: rtl/ysyx_23060124_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_ifu
//
// Instruction fetch unit for the ysyx_23060124 multi-cycle RV32 core.
// Holds the architectural PC, issues one instruction read at a time on an
// AXI4-Lite-style read channel and presents the fetched word plus its PC to
// decode over a valid/ready handshake. After decode takes the instruction the
// unit parks until writeback supplies the next PC, so exactly one instruction
// is ever in flight.
//
// Ports
//   clk           core clock, all state changes on the rising edge
//   i_rst_ifu     synchronous active-high reset
//   i_pc_next     next PC from writeback
//   i_pc_update   writeback strobe, i_pc_next valid this cycle
//   o_araddr      read address (always the current PC)
//   o_arvalid     read address valid
//   i_arready     memory accepts the address
//   i_rdata       read data
//   i_rresp       read response, 2'b00 = OKAY
//   i_rvalid      read data valid
//   o_rready      IFU accepts read data
//   o_inst        fetched instruction (zero on a fault)
//   o_pc          PC of o_inst (always the current PC)
//   o_inst_fault  bus error or misaligned PC, qualified by o_post_valid
//   o_post_valid  instruction available to decode
//   i_post_ready  decode accepts the instruction
// ----------------------------------------------------------------------------
module ysyx_23060124_ifu #(
    parameter int unsigned          ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 i_rst_ifu,
    input  logic [ISA_WIDTH-1:0] i_pc_next,
    input  logic                 i_pc_update,
    output logic [ISA_WIDTH-1:0] o_araddr,
    output logic                 o_arvalid,
    input  logic                 i_arready,
    input  logic [ISA_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_rresp,
    input  logic                 i_rvalid,
    output logic                 o_rready,
    output logic [ISA_WIDTH-1:0] o_inst,
    output logic [ISA_WIDTH-1:0] o_pc,
    output logic                 o_inst_fault,
    output logic                 o_post_valid,
    input  logic                 i_post_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_WAIT_PC
    } state_t;

    state_t                 state_q, state_d;
    logic [ISA_WIDTH-1:0]   pc_q,    pc_d;
    logic [ISA_WIDTH-1:0]   inst_q,  inst_d;
    logic                   fault_q, fault_d;
    logic                   misaligned;
    logic                   bus_err;

    // A word fetch needs a 4-byte aligned PC; otherwise the request is never
    // put on the bus and the fault is reported straight to decode.
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign bus_err    = (i_rresp != 2'b00);

    always_comb begin
        // NOTE: every signal gets its hold value first so that no branch of the
        // case below can leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (misaligned) begin
                    inst_d  = '0;
                    fault_d = 1'b1;
                    state_d = S_VALID;
                end else if (i_arready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rvalid) begin
                    fault_d = bus_err;
                    inst_d  = bus_err ? '0 : i_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (i_post_ready) begin
                    state_d = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                // The PC is taken verbatim; a misaligned value is caught on
                // the following fetch rather than silently masked here.
                if (i_pc_update) begin
                    pc_d    = i_pc_next;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (i_rst_ifu) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Outputs come from registers and state only, never from an input.
    assign o_arvalid    = (state_q == S_FETCH) && !misaligned;
    assign o_araddr     = pc_q;
    assign o_rready     = (state_q == S_WAIT);
    assign o_post_valid = (state_q == S_VALID);
    assign o_inst       = inst_q;
    assign o_inst_fault = fault_q;
    assign o_pc         = pc_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_23060124_ifu. The bench plays the memory slave, decode and
// writeback roles. Expected fetch results follow the fetch rules directly:
// a misaligned PC or a non-OKAY response yields instruction 0 with the fault
// flag set, otherwise the returned word; the PC only moves on a writeback
// update once decode has taken the instruction.
// ----------------------------------------------------------------------------
module tb_ysyx_23060124_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        i_rst_ifu;
    logic [31:0] i_pc_next;
    logic        i_pc_update;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_inst_fault;
    logic        o_post_valid;
    logic        i_post_ready;

    int          checks;
    int          errors;
    logic [31:0] model_pc;

    ysyx_23060124_ifu #(
        .ISA_WIDTH (32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk          (clk),
        .i_rst_ifu    (i_rst_ifu),
        .i_pc_next    (i_pc_next),
        .i_pc_update  (i_pc_update),
        .o_araddr     (o_araddr),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_inst_fault (o_inst_fault),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [1:0]  resp;
        int          ar_dly;
        int          r_dly;
        int          post_dly;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs set then
    // are seen by the DUT at the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Noise on inputs the DUT must ignore in the current state.
    task automatic junk(input bit with_rvalid);
        i_pc_update = 1'($urandom_range(0, 1));
        i_pc_next   = $urandom;
        if (with_rvalid) begin
            i_rvalid = 1'($urandom_range(0, 1));
            i_rdata  = $urandom;
            i_rresp  = 2'($urandom);
        end
    endtask

    task automatic quiet();
        i_pc_update = 1'b0;
        i_rvalid    = 1'b0;
    endtask

    // Entry: waiting for writeback. Exit: fetch state at the new PC.
    task automatic go_to(input logic [31:0] pc, input int wb_dly);
        for (int i = 0; i < wb_dly; i++) begin
            check("waitpc_arvalid", 32'(o_arvalid), 0);
            check("waitpc_post_valid", 32'(o_post_valid), 0);
            check("waitpc_pc", o_pc, model_pc);
            tick();
        end
        i_pc_update = 1'b1;
        i_pc_next   = pc;
        tick();
        i_pc_update = 1'b0;
        i_pc_next   = $urandom;
        model_pc    = pc;
        check("pc_after_update", o_pc, model_pc);
    endtask

    // Entry: fetch state at pc. Exit: waiting for writeback.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data, input logic [1:0] resp,
                             input int ar_dly, input int r_dly, input int post_dly,
                             input logic [31:0] exp_inst, input logic exp_fault);
        check("fetch_pc", o_pc, pc);
        if (pc[1:0] != 2'b00) begin
            check("misaligned_no_arvalid", 32'(o_arvalid), 0);
            check("misaligned_no_post_yet", 32'(o_post_valid), 0);
            tick();
        end else begin
            check("arvalid", 32'(o_arvalid), 1);
            check("araddr", o_araddr, pc);
            check("rready_before_ar", 32'(o_rready), 0);
            for (int i = 0; i < ar_dly; i++) begin
                junk(1'b1);
                tick();
                check("arvalid_held", 32'(o_arvalid), 1);
                check("araddr_held", o_araddr, pc);
                check("rready_before_ar", 32'(o_rready), 0);
            end
            quiet();
            i_arready = 1'b1;
            tick();
            i_arready = 1'b0;
            check("rready", 32'(o_rready), 1);
            check("arvalid_after_accept", 32'(o_arvalid), 0);
            for (int i = 0; i < r_dly; i++) begin
                junk(1'b0);
                tick();
                check("rready_held", 32'(o_rready), 1);
                check("no_post_while_wait", 32'(o_post_valid), 0);
                check("pc_while_wait", o_pc, pc);
            end
            quiet();
            i_rvalid = 1'b1;
            i_rdata  = data;
            i_rresp  = resp;
            tick();
            i_rvalid = 1'b0;
            i_rdata  = $urandom;
            i_rresp  = 2'($urandom);
        end
        check("post_valid", 32'(o_post_valid), 1);
        check("inst", o_inst, exp_inst);
        check("inst_fault", 32'(o_inst_fault), 32'(exp_fault));
        check("post_pc", o_pc, pc);
        check("rready_in_valid", 32'(o_rready), 0);
        for (int i = 0; i < post_dly; i++) begin
            junk(1'b1);
            tick();
            check("post_valid_held", 32'(o_post_valid), 1);
            check("inst_held", o_inst, exp_inst);
            check("fault_held", 32'(o_inst_fault), 32'(exp_fault));
            check("pc_held", o_pc, pc);
        end
        quiet();
        i_post_ready = 1'b1;
        tick();
        i_post_ready = 1'b0;
        check("post_valid_drop", 32'(o_post_valid), 0);
        check("no_arvalid_waitpc", 32'(o_arvalid), 0);
    endtask

    initial begin
        logic [31:0] r_pc;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        r_fault;

        checks       = 0;
        errors       = 0;
        i_rst_ifu    = 1'b1;
        i_pc_next    = '0;
        i_pc_update  = 1'b0;
        i_arready    = 1'b0;
        i_rdata      = '0;
        i_rresp      = '0;
        i_rvalid     = 1'b0;
        i_post_ready = 1'b0;
        model_pc     = RESET_PC;

        //            pc             data           resp   ar r  post exp_inst       fault
        vecs[0] = '{32'h8000_0004, 32'h0000_0093, 2'b00, 0, 0, 0, 32'h0000_0093, 1'b0};
        vecs[1] = '{32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 1, 1, 5, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h8000_0006, 32'h1111_1111, 2'b00, 0, 0, 2, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h8000_0010, 32'h1234_5678, 2'b00, 3, 2, 5, 32'h1234_5678, 1'b0};
        vecs[4] = '{32'h8000_0001, 32'h2222_2222, 2'b00, 0, 0, 0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h8000_0020, 32'hCAFE_F00D, 2'b01, 2, 0, 1, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h8000_0024, 32'hFFFF_FFFF, 2'b11, 0, 3, 0, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0073, 2'b00, 1, 0, 3, 32'h0000_0073, 1'b0};

        // Reset values.
        tick();
        tick();
        check("rst_arvalid", 32'(o_arvalid), 0);
        check("rst_rready", 32'(o_rready), 0);
        check("rst_post_valid", 32'(o_post_valid), 0);
        check("rst_inst", o_inst, 0);
        check("rst_fault", 32'(o_inst_fault), 0);
        check("rst_pc", o_pc, RESET_PC);
        check("rst_araddr", o_araddr, RESET_PC);

        // Best case, cycle by cycle from reset release (cycle 0 = idle).
        i_rst_ifu = 1'b0;
        i_arready = 1'b1;
        check("c0_idle_arvalid", 32'(o_arvalid), 0);
        tick();
        check("c1_arvalid", 32'(o_arvalid), 1);
        check("c1_araddr", o_araddr, RESET_PC);
        tick();
        i_arready = 1'b0;
        check("c2_rready", 32'(o_rready), 1);
        i_rvalid = 1'b1;
        i_rdata  = 32'h0000_0013;
        i_rresp  = 2'b00;
        tick();
        i_rvalid = 1'b0;
        check("c3_post_valid", 32'(o_post_valid), 1);
        check("c3_inst", o_inst, 32'h0000_0013);
        check("c3_pc", o_pc, RESET_PC);
        check("c3_fault", 32'(o_inst_fault), 0);
        i_post_ready = 1'b1;
        tick();
        i_post_ready = 1'b0;
        check("c4_post_valid", 32'(o_post_valid), 0);
        check("c4_arvalid", 32'(o_arvalid), 0);

        // Directed vectors; the first update lands at cycle 4 so its fetch
        // shows up at cycle 5.
        for (int v = 0; v < 8; v++) begin
            go_to(vecs[v].pc, v % 3);
            fetch_one(vecs[v].pc, vecs[v].data, vecs[v].resp, vecs[v].ar_dly, vecs[v].r_dly,
                      vecs[v].post_dly, vecs[v].exp_inst, vecs[v].exp_fault);
        end

        // Reset while waiting for read data.
        go_to(32'h8000_0040, 1);
        check("pre_rst_arvalid", 32'(o_arvalid), 1);
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
        check("pre_rst_rready", 32'(o_rready), 1);
        i_rst_ifu = 1'b1;
        tick();
        i_rst_ifu = 1'b0;
        model_pc  = RESET_PC;
        check("midrst_arvalid", 32'(o_arvalid), 0);
        check("midrst_rready", 32'(o_rready), 0);
        check("midrst_post_valid", 32'(o_post_valid), 0);
        check("midrst_inst", o_inst, 0);
        check("midrst_fault", 32'(o_inst_fault), 0);
        check("midrst_pc", o_pc, RESET_PC);
        tick();
        fetch_one(RESET_PC, 32'h0000_0013, 2'b00, 0, 0, 0, 32'h0000_0013, 1'b0);

        // Randomized transactions against the fetch rules.
        for (int n = 0; n < 40; n++) begin
            r_pc = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 7) == 0) r_pc = r_pc + 32'($urandom_range(1, 3));
            r_data  = $urandom;
            r_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_fault = (r_pc[1:0] != 2'b00) || (r_resp != 2'b00);
            go_to(r_pc, $urandom_range(0, 2));
            fetch_one(r_pc, r_data, r_resp, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), r_fault ? 32'h0 : r_data, r_fault);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_ifu.md
# ysyx_23060124_ifu

Instruction fetch unit for the ysyx_23060124 multi-cycle RV32 core. Owns the architectural PC register, issues one instruction read at a time on an AXI4-Lite-style read channel, and hands the fetched word and its PC to the decode stage over a valid/ready handshake. It is the sink of the writeback stage's next-PC/update pair and closes the fetch→execute→writeback loop: it does not fetch again until writeback reports the next PC.

## Interface
- ISA_WIDTH, 32, data/address width
- RESET_PC, 32'h8000_0000, PC loaded on reset
- clk  in  1  core clock; all state changes on rising edge
- i_rst_ifu  in  1  reset; synchronous, active-high
- i_pc_next  in  ISA_WIDTH  next PC from writeback
- i_pc_update  in  1  writeback strobe; i_pc_next valid this cycle
- o_araddr  out  ISA_WIDTH  read address (equals current PC)
- o_arvalid  out  1  read address valid
- i_arready  in  1  memory accepts address
- i_rdata  in  ISA_WIDTH  read data
- i_rresp  in  2  read response; 2'b00 = OKAY
- i_rvalid  in  1  read data valid
- o_rready  out  1  IFU accepts read data
- o_inst  out  ISA_WIDTH  fetched instruction to decode
- o_pc  out  ISA_WIDTH  PC of o_inst
- o_inst_fault  out  1  fetch fault (bus error or misaligned PC), qualified by o_post_valid
- o_post_valid  out  1  instruction available to decode
- i_post_ready  in  1  decode accepts instruction

## Operation
- States: S_IDLE, S_FETCH, S_WAIT, S_VALID, S_WAIT_PC. One instruction in flight; no prefetch.
- S_IDLE: entered on reset; all handshake outputs low; next cycle → S_FETCH.
- S_FETCH: o_arvalid=1, o_araddr=pc. If pc[1:0]!=0: no request issued (o_arvalid=0), o_inst_fault←1, o_inst←0, → S_VALID. Else on i_arready: → S_WAIT. o_arvalid held with stable address until accepted.
- S_WAIT: o_rready=1. On i_rvalid: o_inst←i_rdata, o_inst_fault←(i_rresp!=0); if fault, o_inst←0; → S_VALID. i_rvalid in any other state is not accepted (o_rready=0).
- S_VALID: o_post_valid=1; o_inst, o_pc, o_inst_fault held stable. On i_post_ready: → S_WAIT_PC.
- S_WAIT_PC: on i_pc_update: pc←i_pc_next (no alignment masking), → S_FETCH.
- i_pc_update in any state other than S_WAIT_PC is ignored; pc unchanged.
- o_pc always equals pc register; o_araddr equals pc.
- Reset mid-transaction: state→S_IDLE, pc←RESET_PC, outputs to reset values; the memory slave shares i_rst_ifu, so no stale R beat is outstanding.

## Timing
- Reset values: o_arvalid 0, o_rready 0, o_post_valid 0, o_inst 0, o_inst_fault 0, o_pc RESET_PC, o_araddr RESET_PC.
- All outputs registered or decoded from state only; no combinational path from any input to any output.
- Best case, zero-wait memory (i_arready=1, i_rvalid the cycle after address accepted), i_post_ready=1, i_pc_update one cycle after acceptance: reset released at cycle 0 (S_IDLE); cycle 1 arvalid; cycle 2 rready/rvalid; cycle 3 post_valid; cycle 4 S_WAIT_PC with pc_update; cycle 5 arvalid at new PC. Per-instruction loop = 4 cycles + memory and backend waits.
- Misaligned PC: S_FETCH → S_VALID in 1 cycle, no bus activity.
- Handshake completes on the rising edge where valid && ready; valid never drops before completion.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0013 at 32'h8000_0000 -> o_arvalid at cycle 1 with o_araddr=32'h8000_0000, o_post_valid at cycle 3 with o_inst=32'h0000_0013, o_pc=32'h8000_0000, o_inst_fault=0.
- i_arready delayed 3 cycles, i_rvalid delayed 2 more -> o_arvalid and o_araddr stable throughout; o_rready only after address accepted; o_inst captured correctly.
- i_post_ready held low 5 cycles, i_pc_update pulsed during S_VALID -> o_inst/o_pc stable, pulse ignored, pc unchanged; later pc_update with 32'h8000_0010 in S_WAIT_PC -> next o_araddr=32'h8000_0010.
- i_rresp=2'b10 with i_rdata=32'hDEAD_BEEF -> o_post_valid with o_inst=0, o_inst_fault=1.
- i_pc_next=32'h8000_0006 -> no o_arvalid; o_post_valid next cycle with o_inst_fault=1, o_pc=32'h8000_0006.
- i_rst_ifu asserted during S_WAIT -> next cycle all handshake outputs 0, o_pc=32'h8000_0000; fetch restarts at cycle 1 after release.
